date_counter: RTL

- Calendar date register for the alarm clock. Sits directly upstream of the date display and alarm-date compare, and downstream of the time-of-day counter.
- Advances day, month and year on each midnight pulse (day_tick) from the time-of-day counter.
- Applies true month lengths, including leap-year February, internally.
- Supports button-driven date editing and a bulk date load.
- Month numbering is 0 = January .. 11 = December. Day numbering is 1..31. Year is an offset from 2000 (0..99).

---
 rtl/date_counter_pkg.sv | 46 ++++
 rtl/date_counter_if.sv | 42 ++++
 rtl/date_counter_days_in_month.sv | 18 +
 rtl/date_counter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/date_counter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : calendar_pkg                                           |
// | Brief   : Field widths, month indices and month-length table     |
// |           shared by the date counter and its sub-modules.        |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package calendar_pkg;

  localparam int DAY_W   = 6;
  localparam int MONTH_W = 6;
  localparam int YEAR_W  = 7;

  localparam logic [MONTH_W-1:0] JAN = 6'd0;
  localparam logic [MONTH_W-1:0] FEB = 6'd1;
  localparam logic [MONTH_W-1:0] MAR = 6'd2;
  localparam logic [MONTH_W-1:0] APR = 6'd3;
  localparam logic [MONTH_W-1:0] MAY = 6'd4;
  localparam logic [MONTH_W-1:0] JUN = 6'd5;
  localparam logic [MONTH_W-1:0] JUL = 6'd6;
  localparam logic [MONTH_W-1:0] AUG = 6'd7;
  localparam logic [MONTH_W-1:0] SEP = 6'd8;
  localparam logic [MONTH_W-1:0] OCT = 6'd9;
  localparam logic [MONTH_W-1:0] NOV = 6'd10;
  localparam logic [MONTH_W-1:0] DEC = 6'd11;

  // Non-leap lengths; February is patched to 29 in month_length().
  localparam logic [DAY_W-1:0] MONTH_LEN [12] = '{
    6'd31, 6'd28, 6'd31, 6'd30, 6'd31, 6'd30,
    6'd31, 6'd31, 6'd30, 6'd31, 6'd30, 6'd31
  };

  // Length of month m; an out-of-range month yields 0 so no day can match it.
  function automatic logic [DAY_W-1:0] month_length(input logic [MONTH_W-1:0] m,
                                                    input logic               lp);
    logic [DAY_W-1:0] len;
    len = '0;
    if (m <= DEC) begin
      len = MONTH_LEN[m[3:0]];
      if ((m == FEB) && lp) len = 6'd29;
    end
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/date_counter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : date_counter_if                                      |
// | Brief     : Tick, edit and load controls plus date outputs of    |
// |             the calendar date register.                          |
// | Rev       : 1.0  initial release                                 |
// +------------------------------------------------------------------+
interface date_counter_if;
  import calendar_pkg::*;

  logic               day_tick;
  logic               edit_en;
  logic               inc_day;
  logic               inc_month;
  logic               inc_year;
  logic               set_load;
  logic [DAY_W-1:0]   set_day;
  logic [MONTH_W-1:0] set_month;
  logic [YEAR_W-1:0]  set_year;
  logic [DAY_W-1:0]   day;
  logic [MONTH_W-1:0] month;
  logic [YEAR_W-1:0]  year;
  logic               leap;
  logic               month_rollover;
  logic               year_rollover;
  logic               set_err;

  // Controller side: drives ticks/edits, observes the date.
  modport master (
    output day_tick, edit_en, inc_day, inc_month, inc_year,
           set_load, set_day, set_month, set_year,
    input  day, month, year, leap, month_rollover, year_rollover, set_err
  );

  // Date register side.
  modport slave (
    input  day_tick, edit_en, inc_day, inc_month, inc_year,
           set_load, set_day, set_month, set_year,
    output day, month, year, leap, month_rollover, year_rollover, set_err
  );
endinterface
`default_nettype wire

// File: rtl/date_counter_days_in_month.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : days_in_month                                           |
// | Brief  : Combinational month-length lookup with leap February.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module days_in_month
  import calendar_pkg::*;
(
  input  wire logic [MONTH_W-1:0] month,
  input  wire logic               leap,
  output logic      [DAY_W-1:0]   mdays
);

  assign mdays = month_length(month, leap);

endmodule
`default_nettype wire

// File: rtl/date_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : date_counter                                            |
// | Brief  : Calendar date register advanced by midnight ticks, with |
// |          button editing, bulk load and held-off ticks in edit.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module date_counter
  import calendar_pkg::*;
#(
  parameter int YEAR_MAX    = 99,
  parameter int RESET_DAY   = 1,
  parameter int RESET_MONTH = 0,
  parameter int RESET_YEAR  = 18
) (
  input  wire logic        clk,
  input  wire logic        reset,
  date_counter_if.slave    bus
);

  localparam logic [YEAR_W-1:0]  c_year_max = YEAR_W'(YEAR_MAX);
  localparam logic [DAY_W-1:0]   c_rst_day  = DAY_W'(RESET_DAY);
  localparam logic [MONTH_W-1:0] c_rst_mon  = MONTH_W'(RESET_MONTH);
  localparam logic [YEAR_W-1:0]  c_rst_year = YEAR_W'(RESET_YEAR);

  logic [DAY_W-1:0]   day_q, day_d;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [YEAR_W-1:0]  year_q, year_d;
  logic               mroll_q, mroll_d;
  logic               yroll_q, yroll_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;

  logic [DAY_W-1:0]   w_mdays;
  logic [DAY_W-1:0]   w_set_mdays;
  logic               w_leap;
  logic               w_set_leap;
  logic               w_set_ok;
  logic [MONTH_W-1:0] w_month_inc;
  logic [YEAR_W-1:0]  w_year_inc;
  logic [DAY_W-1:0]   w_clamp_len;

  // Year offset 0 is 2000, itself a leap year, so %4 holds for the whole range.
  assign w_leap     = (year_q[1:0] == 2'b00);
  assign w_set_leap = (bus.set_year[1:0] == 2'b00);

  days_in_month u_cur_len (
    .month (month_q),
    .leap  (w_leap),
    .mdays (w_mdays)
  );

  days_in_month u_set_len (
    .month (bus.set_month),
    .leap  (w_set_leap),
    .mdays (w_set_mdays)
  );

  assign w_set_ok = (bus.set_month <= DEC) && (bus.set_year <= c_year_max) &&
                    (bus.set_day != '0) && (bus.set_day <= w_set_mdays);

  assign w_month_inc = (month_q >= DEC) ? JAN : (month_q + 6'd1);
  assign w_year_inc  = (year_q >= c_year_max) ? '0 : (year_q + 7'd1);

  // Next-state: load > inc_* > tick; ticks shadowed by a higher event are held pending.
  always_comb begin
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    mroll_d     = 1'b0;
    yroll_d     = 1'b0;
    err_d       = 1'b0;
    pend_d      = pend_q;
    w_clamp_len = w_mdays;
    if (bus.set_load) begin
      if (w_set_ok) begin
        day_d   = bus.set_day;
        month_d = bus.set_month;
        year_d  = bus.set_year;
      end else begin
        err_d = 1'b1;
      end
      if (bus.day_tick) pend_d = 1'b1;
    end else if (bus.inc_day || bus.inc_month || bus.inc_year) begin
      if (bus.inc_day) begin
        day_d = (day_q >= w_mdays) ? 6'd1 : (day_q + 6'd1);
      end else if (bus.inc_month) begin
        month_d     = w_month_inc;
        w_clamp_len = month_length(w_month_inc, w_leap);
        if (day_q > w_clamp_len) day_d = w_clamp_len;
      end else begin
        year_d      = w_year_inc;
        w_clamp_len = month_length(month_q, (w_year_inc[1:0] == 2'b00));
        if (day_q > w_clamp_len) day_d = w_clamp_len;
      end
      if (bus.day_tick) pend_d = 1'b1;
    end else if (bus.edit_en) begin
      if (bus.day_tick) pend_d = 1'b1;
    end else if (bus.day_tick || pend_q) begin
      pend_d = 1'b0;
      if (day_q < w_mdays) begin
        day_d = day_q + 6'd1;
      end else begin
        day_d   = 6'd1;
        mroll_d = 1'b1;
        if (month_q >= DEC) begin
          month_d = JAN;
          year_d  = w_year_inc;
          yroll_d = 1'b1;
        end else begin
          month_d = month_q + 6'd1;
        end
      end
    end
  end

  // Date, pulse and pending-tick registers; reset discards any edit or held tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      day_q   <= c_rst_day;
      month_q <= c_rst_mon;
      year_q  <= c_rst_year;
      mroll_q <= 1'b0;
      yroll_q <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      mroll_q <= mroll_d;
      yroll_q <= yroll_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.day            = day_q;
  assign bus.month          = month_q;
  assign bus.year           = year_q;
  assign bus.leap           = w_leap;
  assign bus.month_rollover = mroll_q;
  assign bus.year_rollover  = yroll_q;
  assign bus.set_err        = err_q;

endmodule
`default_nettype wire
